wb_cpu_bridge: RTL and testbench

Single-master Wishbone bridge between the 8-bit CPU core's memory port and the SoC slaves: ROM, RAM and IO. It decodes each CPU access into exactly one slave strobe and waits for that slave's ack. It returns read data to the CPU with a one-cycle ready pulse. A bounded timeout terminates accesses that are never acknowledged.

---
 rtl/wb_soc_pkg.sv | 34 +++
 rtl/wb_addr_decode.sv | 27 ++
 rtl/wb_cpu_bridge.sv | 178 +++++++++++++++++
 tb/tb_wb_cpu_bridge.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_soc_pkg.sv
// Shared definitions for the CPU-to-Wishbone bridge: memory map, FSM states,
// slave-select encoding and an address range helper.
package wb_soc_pkg;

  // Memory map, inclusive limits, in CPU byte addresses.
  localparam logic [31:0] ROM_BASE  = 32'h0000_F000;
  localparam logic [31:0] ROM_LIMIT = 32'h0000_FFFF;
  localparam logic [31:0] IO_BASE   = 32'h0000_D000;
  localparam logic [31:0] IO_LIMIT  = 32'h0000_D0FF;
  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_LIMIT = 32'h0000_07FF;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ROM,
    SEL_RAM,
    SEL_IO
  } slave_sel_e;

  // Unsigned wrap trick: an address below base wraps to a huge offset,
  // so one comparison covers both bounds (and base = 0 needs no special case).
  function automatic logic in_range(input logic [31:0] adr,
                                    input logic [31:0] base,
                                    input logic [31:0] limit);
    return (adr - base) <= (limit - base);
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational CPU address decoder: maps a byte address onto one slave select.
module wb_addr_decode
  import wb_soc_pkg::*;
#(
  parameter int CPU_ADDR_WIDTH = 16
) (
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_adr_i,
  output slave_sel_e                sel_o
);

  logic [31:0] adr_ext;

  // Regions are disjoint, so the priority order below is irrelevant.
  always_comb begin
    adr_ext = 32'(cpu_adr_i);
    if (in_range(adr_ext, ROM_BASE, ROM_LIMIT)) begin
      sel_o = SEL_ROM;
    end else if (in_range(adr_ext, IO_BASE, IO_LIMIT)) begin
      sel_o = SEL_IO;
    end else if (in_range(adr_ext, RAM_BASE, RAM_LIMIT)) begin
      sel_o = SEL_RAM;
    end else begin
      sel_o = SEL_NONE;
    end
  end

endmodule

// File: rtl/wb_cpu_bridge.sv
// Single-master Wishbone bridge from the 8-bit CPU memory port to ROM, RAM
// and IO slaves. One access at a time: decode, strobe, wait for ack (or time
// out), then pulse cpu_rdy_o for one cycle with the read data.
module wb_cpu_bridge
  import wb_soc_pkg::*;
#(
  parameter int CPU_ADDR_WIDTH = 16,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int WB_ADDR_WIDTH  = 12,
  parameter int TIMEOUT        = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cpu_req_i,
  input  logic                      cpu_we_i,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]  cpu_dat_i,
  output logic [WB_DATA_WIDTH-1:0]  cpu_dat_o,
  output logic                      cpu_rdy_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  output logic                      we_o,
  output logic                      rom_stb_o,
  output logic                      ram_stb_o,
  output logic                      io_stb_o,
  input  logic                      rom_ack_i,
  input  logic                      ram_ack_i,
  input  logic                      io_ack_i,
  input  logic [WB_DATA_WIDTH-1:0]  rom_dat_i,
  input  logic [WB_DATA_WIDTH-1:0]  ram_dat_i,
  input  logic [WB_DATA_WIDTH-1:0]  io_dat_i,
  output logic                      err_o,
  input  logic                      err_clr_i
);

  // Abort fires on the cycle the counter reaches this value without ack.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [WB_DATA_WIDTH-1:0] DAT_ABORT = {WB_DATA_WIDTH{1'b1}};

  state_e                     state_q, state_d;
  slave_sel_e                 sel_q, sel_d;
  slave_sel_e                 dec_sel;
  logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                       we_q, we_d;
  logic [WB_DATA_WIDTH-1:0]   cpu_dat_q, cpu_dat_d;
  logic                       rdy_q, rdy_d;
  logic                       err_q, err_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       ack_sel;
  logic [WB_DATA_WIDTH-1:0]   dat_sel;
  logic                       err_set;

  wb_addr_decode #(
    .CPU_ADDR_WIDTH (CPU_ADDR_WIDTH)
  ) u_decode (
    .cpu_adr_i (cpu_adr_i),
    .sel_o     (dec_sel)
  );

  // Route only the selected slave's ack and data; the others are ignored.
  always_comb begin
    // NOTE: every combinational output gets a value on every path (here via
    // defaults) so no latch is inferred.
    ack_sel = 1'b0;
    dat_sel = '0;
    case (sel_q)
      SEL_ROM: begin ack_sel = rom_ack_i; dat_sel = rom_dat_i; end
      SEL_RAM: begin ack_sel = ram_ack_i; dat_sel = ram_dat_i; end
      SEL_IO:  begin ack_sel = io_ack_i;  dat_sel = io_dat_i;  end
      default: begin ack_sel = 1'b0;      dat_sel = '0;        end
    endcase
  end

  // Next-state logic for the access sequencer and its registered outputs.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    cpu_dat_d = cpu_dat_q;
    cnt_d     = cnt_q;
    rdy_d     = 1'b0;
    err_set   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // Acks arriving here (e.g. the late ack of a registered-ack slave)
        // are deliberately not looked at.
        if (cpu_req_i) begin
          adr_d = cpu_adr_i[WB_ADDR_WIDTH-1:0];
          dat_d = cpu_dat_i;
          we_d  = cpu_we_i;
          sel_d = dec_sel;
          if (dec_sel == SEL_NONE) begin
            cpu_dat_d = DAT_ABORT;
            rdy_d     = 1'b1;
            state_d   = DONE;
          end else begin
            cnt_d   = '0;
            state_d = BUS;
          end
        end else begin
          sel_d   = SEL_NONE;
          state_d = IDLE;
        end
      end

      BUS: begin
        if (ack_sel) begin
          if (!we_q) begin
            cpu_dat_d = dat_sel;
          end
          rdy_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          cpu_dat_d = DAT_ABORT;
          err_set   = 1'b1;
          rdy_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        sel_d   = SEL_NONE;
        state_d = IDLE;
      end
    endcase

    // A timeout in the same cycle as a clear request keeps the flag set.
    err_d = err_set | (err_q & ~err_clr_i);
  end

  // State and output registers, asynchronously reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q   <= IDLE;
      sel_q     <= SEL_NONE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      cpu_dat_q <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      cpu_dat_q <= cpu_dat_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Strobes come straight from registered state, so reset drops them at once.
  always_comb begin
    rom_stb_o = (state_q == BUS) && (sel_q == SEL_ROM);
    ram_stb_o = (state_q == BUS) && (sel_q == SEL_RAM);
    io_stb_o  = (state_q == BUS) && (sel_q == SEL_IO);
  end

  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign we_o      = we_q;
  assign cpu_dat_o = cpu_dat_q;
  assign cpu_rdy_o = rdy_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_wb_cpu_bridge.sv
// Directed bench for wb_cpu_bridge with small ROM/RAM slave models and an IO
// slave that never acknowledges.
module tb_wb_cpu_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [15:0] cpu_adr_i = '0;
  logic [7:0]  cpu_dat_i = '0;
  logic [7:0]  cpu_dat_o;
  logic        cpu_rdy_o;
  logic [11:0] adr_o;
  logic [7:0]  dat_o;
  logic        we_o;
  logic        rom_stb_o, ram_stb_o, io_stb_o;
  logic        rom_ack_i, ram_ack_i, io_ack_i;
  logic [7:0]  rom_dat_i, ram_dat_i, io_dat_i;
  logic        err_o;
  logic        err_clr_i = 1'b0;

  logic        rom_ack_m;
  logic        ram_ack_m;
  logic        ram_ack_force = 1'b0;
  logic [7:0]  rom_mem [0:4095];
  logic [7:0]  ram_mem [0:4095];

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  wb_cpu_bridge #(
    .CPU_ADDR_WIDTH (16),
    .WB_DATA_WIDTH  (8),
    .WB_ADDR_WIDTH  (12),
    .TIMEOUT        (15)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cpu_req_i (cpu_req_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_adr_i (cpu_adr_i),
    .cpu_dat_i (cpu_dat_i),
    .cpu_dat_o (cpu_dat_o),
    .cpu_rdy_o (cpu_rdy_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .we_o      (we_o),
    .rom_stb_o (rom_stb_o),
    .ram_stb_o (ram_stb_o),
    .io_stb_o  (io_stb_o),
    .rom_ack_i (rom_ack_i),
    .ram_ack_i (ram_ack_i),
    .io_ack_i  (io_ack_i),
    .rom_dat_i (rom_dat_i),
    .ram_dat_i (ram_dat_i),
    .io_dat_i  (io_dat_i),
    .err_o     (err_o),
    .err_clr_i (err_clr_i)
  );

  // ROM: registered single-pulse ack one cycle after stb.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rom_ack_m <= 1'b0;
    else       rom_ack_m <= rom_stb_o & ~rom_ack_m;
  end

  // RAM: plain registered ack (ack follows stb), so a stale ack appears
  // one cycle after stb falls; writes land while stb and we are high.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ram_ack_m <= 1'b0;
    end else begin
      ram_ack_m <= ram_stb_o;
      if (ram_stb_o && we_o) ram_mem[adr_o] <= dat_o;
    end
  end

  assign rom_ack_i = rom_ack_m;
  assign ram_ack_i = ram_ack_m | ram_ack_force;
  assign io_ack_i  = 1'b0;
  assign rom_dat_i = rom_mem[adr_o];
  assign ram_dat_i = ram_mem[adr_o];
  assign io_dat_i  = 8'h3C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start(input logic we, input logic [15:0] adr, input logic [7:0] dat);
    cpu_req_i = 1'b1;
    cpu_we_i  = we;
    cpu_adr_i = adr;
    cpu_dat_i = dat;
  endtask

  logic [15:0] bnd_adr [6];
  logic [2:0]  bnd_stb [6];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rom_mem[i] = 8'h11;
      ram_mem[i] = 8'h00;
    end
    rom_mem[12'hFFC] = 8'h00;
    rom_mem[12'hFFD] = 8'hF0;
    ram_mem[12'h7FF] = 8'hA5;

    // Reset values.
    step();
    check("rst_rdy",  32'(cpu_rdy_o), 32'h0);
    check("rst_cdat", 32'(cpu_dat_o), 32'h00);
    check("rst_adr",  32'(adr_o),     32'h0);
    check("rst_dat",  32'(dat_o),     32'h00);
    check("rst_we",   32'(we_o),      32'h0);
    check("rst_stb",  32'({rom_stb_o, ram_stb_o, io_stb_o}), 32'h0);
    check("rst_err",  32'(err_o),     32'h0);
    rst_i = 1'b0;
    step();

    // ROM read 0xFFFC: stb in cycle 1, rdy with data in cycle 3.
    start(1'b0, 16'hFFFC, 8'h00);
    step();
    cpu_req_i = 1'b0;
    check("rom1_stb_c1", 32'(rom_stb_o), 32'h1);
    check("rom1_adr_c1", 32'(adr_o),     32'hFFC);
    check("rom1_rdy_c1", 32'(cpu_rdy_o), 32'h0);
    step();
    check("rom1_rdy_c2", 32'(cpu_rdy_o), 32'h0);
    step();
    check("rom1_rdy_c3", 32'(cpu_rdy_o), 32'h1);
    check("rom1_dat_c3", 32'(cpu_dat_o), 32'h00);
    check("rom1_stb_c3", 32'(rom_stb_o), 32'h0);
    step();
    check("rom1_rdy_c4", 32'(cpu_rdy_o), 32'h0);

    // ROM read 0xFFFD with a non-selected RAM ack pulsed in cycles 1..2.
    start(1'b0, 16'hFFFD, 8'h00);
    step();
    cpu_req_i = 1'b0;
    ram_ack_force = 1'b1;
    check("rom2_stb_c1", 32'(rom_stb_o), 32'h1);
    step();
    check("rom2_rdy_c2", 32'(cpu_rdy_o), 32'h0);
    check("rom2_stb_c2", 32'(rom_stb_o), 32'h1);
    ram_ack_force = 1'b0;
    step();
    check("rom2_rdy_c3", 32'(cpu_rdy_o), 32'h1);
    check("rom2_dat_c3", 32'(cpu_dat_o), 32'hF0);
    step();
    step();

    // RAM write 0x0004 = 0xFF.
    start(1'b1, 16'h0004, 8'hFF);
    step();
    cpu_req_i = 1'b0;
    check("ramw_stb_c1", 32'(ram_stb_o), 32'h1);
    check("ramw_we_c1",  32'(we_o),      32'h1);
    check("ramw_dat_c1", 32'(dat_o),     32'hFF);
    check("ramw_adr_c1", 32'(adr_o),     32'h004);
    cpu_dat_i = 8'h00;
    step();
    check("ramw_dat_c2", 32'(dat_o),     32'hFF);
    step();
    check("ramw_rdy_c3", 32'(cpu_rdy_o), 32'h1);
    check("ramw_cdat_c3", 32'(cpu_dat_o), 32'hF0);
    step();
    step();

    // RAM read 0x0004 with the request held through DONE: second access
    // re-strobes in cycle 4 while the stale ack is present in cycle 3.
    start(1'b0, 16'h0004, 8'h00);
    step();
    check("ramr_stb_c1", 32'(ram_stb_o), 32'h1);
    check("ramr_we_c1",  32'(we_o),      32'h0);
    step();
    step();
    check("ramr_rdy_c3", 32'(cpu_rdy_o), 32'h1);
    check("ramr_dat_c3", 32'(cpu_dat_o), 32'hFF);
    check("ramr_stb_c3", 32'(ram_stb_o), 32'h0);
    step();
    cpu_req_i = 1'b0;
    check("b2b_stb_c4", 32'(ram_stb_o), 32'h1);
    check("b2b_rdy_c4", 32'(cpu_rdy_o), 32'h0);
    step();
    check("b2b_rdy_c5", 32'(cpu_rdy_o), 32'h0);
    step();
    check("b2b_rdy_c6", 32'(cpu_rdy_o), 32'h1);
    check("b2b_dat_c6", 32'(cpu_dat_o), 32'hFF);
    step();
    step();

    // Unmapped read 0x8000: rdy in cycle 1 with 0xFF, no strobe, no error.
    start(1'b0, 16'h8000, 8'h00);
    step();
    cpu_req_i = 1'b0;
    check("unm_rdy_c1", 32'(cpu_rdy_o), 32'h1);
    check("unm_dat_c1", 32'(cpu_dat_o), 32'hFF);
    check("unm_stb_c1", 32'({rom_stb_o, ram_stb_o, io_stb_o}), 32'h0);
    check("unm_err_c1", 32'(err_o),     32'h0);
    step();
    check("unm_stb_c2", 32'({rom_stb_o, ram_stb_o, io_stb_o}), 32'h0);
    check("unm_rdy_c2", 32'(cpu_rdy_o), 32'h0);
    step();

    // Map boundaries: {rom,ram,io} strobe and rdy in cycle 1.
    bnd_adr[0] = 16'h07FF; bnd_stb[0] = 3'b010;
    bnd_adr[1] = 16'h0800; bnd_stb[1] = 3'b000;
    bnd_adr[2] = 16'hCFFF; bnd_stb[2] = 3'b000;
    bnd_adr[3] = 16'hD100; bnd_stb[3] = 3'b000;
    bnd_adr[4] = 16'hEFFF; bnd_stb[4] = 3'b000;
    bnd_adr[5] = 16'hF000; bnd_stb[5] = 3'b100;
    for (int i = 0; i < 6; i++) begin
      start(1'b0, bnd_adr[i], 8'h00);
      step();
      cpu_req_i = 1'b0;
      check($sformatf("bnd_stb_%04h", bnd_adr[i]),
            32'({rom_stb_o, ram_stb_o, io_stb_o}), 32'(bnd_stb[i]));
      check($sformatf("bnd_rdy_%04h", bnd_adr[i]),
            32'(cpu_rdy_o), 32'(bnd_stb[i] == 3'b000));
      if (bnd_stb[i] != 3'b000) begin
        step();
        step();
      end
      step();
      step();
    end

    // IO timeout at 0xD0FF: stb in cycles 1..15, rdy with 0xFF in cycle 16.
    start(1'b0, 16'hD0FF, 8'h00);
    step();
    cpu_req_i = 1'b0;
    check("io_adr_c1", 32'(adr_o), 32'h0FF);
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("io_stb_c%0d", c), 32'(io_stb_o),  32'h1);
      check($sformatf("io_rdy_c%0d", c), 32'(cpu_rdy_o), 32'h0);
      step();
    end
    check("io_stb_c16", 32'(io_stb_o),  32'h0);
    check("io_rdy_c16", 32'(cpu_rdy_o), 32'h1);
    check("io_dat_c16", 32'(cpu_dat_o), 32'hFF);
    check("io_err_c16", 32'(err_o),     32'h1);
    step();
    check("io_err_sticky", 32'(err_o), 32'h1);

    // Clear pulse.
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check("err_clr", 32'(err_o), 32'h0);
    step();

    // Second timeout at 0xD000 with clear coincident with the abort cycle.
    start(1'b0, 16'hD000, 8'h00);
    step();
    cpu_req_i = 1'b0;
    check("io2_stb_c1", 32'(io_stb_o), 32'h1);
    repeat (14) step();
    check("io2_stb_c15", 32'(io_stb_o), 32'h1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check("io2_rdy_c16", 32'(cpu_rdy_o), 32'h1);
    check("io2_err_set_wins", 32'(err_o), 32'h1);
    step();

    // Reset in cycle 1 of a ROM read: strobe drops without a clock edge.
    start(1'b0, 16'hFFFC, 8'h00);
    step();
    cpu_req_i = 1'b0;
    check("rstm_stb_c1", 32'(rom_stb_o), 32'h1);
    #1;
    rst_i = 1'b1;
    #1;
    check("rstm_stb_async", 32'(rom_stb_o), 32'h0);
    check("rstm_rdy",  32'(cpu_rdy_o), 32'h0);
    check("rstm_cdat", 32'(cpu_dat_o), 32'h00);
    check("rstm_adr",  32'(adr_o),     32'h0);
    check("rstm_dat",  32'(dat_o),     32'h00);
    check("rstm_we",   32'(we_o),      32'h0);
    check("rstm_err",  32'(err_o),     32'h0);
    step();
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rstm_after_rdy_%0d", c), 32'(cpu_rdy_o), 32'h0);
      check($sformatf("rstm_after_stb_%0d", c),
            32'({rom_stb_o, ram_stb_o, io_stb_o}), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
